// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory answering CPU load/store requests with wait states and error flagging
module data_mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdata;
  logic        r_ack, r_err;
  logic [31:0] mem [DEPTH];
  logic        w_idle, w_we, w_legal, w_enter_resp, w_commit;
  logic [31:0] w_addr, w_wdata;
  logic [3:0]  w_be;
  logic [AW-1:0] w_idx;
  // In IDLE the live inputs are the request (they are being latched this edge); afterwards the latched copy is used
  assign w_idle       = r_state == S_IDLE;
  assign w_we         = w_idle ? we    : r_we;
  assign w_addr       = w_idle ? addr  : r_addr;
  assign w_wdata      = w_idle ? wdata : r_wdata;
  assign w_be         = w_idle ? be    : r_be;
  assign w_idx        = w_addr[AW+1:2];
  assign w_legal      = (w_addr[1:0] == 2'b00) && (w_addr[31:AW+2] == '0);
  assign w_enter_resp = (w_idle && req && (WAIT_CYCLES == 0 || !w_legal)) || (r_state == S_WAIT && r_cnt == 4'd0);
  assign w_commit     = w_enter_resp && w_legal && w_we && !Reset;
  assign rdata        = r_rdata;
  assign ack          = r_ack;
  assign err          = r_err;
  assign busy         = !w_idle;
  // State register
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) r_state <= S_IDLE;
    else r_state <= w_next;
  // Next state: illegal or zero-wait requests skip WAIT entirely
  always_comb begin
    w_next = r_state;
    if (w_enter_resp) w_next = S_RESP;
    else if (w_idle && req) w_next = S_WAIT;
    else if (r_state == S_RESP) w_next = S_IDLE;
  end
  // Latch the request on acceptance and count down the wait states
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_idle && req) begin
      r_cnt   <= CNT_INIT;
      r_we    <= we;
      r_addr  <= addr;
      r_wdata <= wdata;
      r_be    <= be;
    end else if (r_state == S_WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
  // Registered response: valid only during the single RESP cycle, zero otherwise
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_enter_resp;
      r_err   <= w_enter_resp && !w_legal;
      r_rdata <= (w_enter_resp && w_legal && !w_we) ? mem[w_idx] : '0;
    end
  // Byte-enabled store commit on the edge entering RESP; the array itself is never reset
  always_ff @(posedge CLK)
    if (w_commit)
      for (int i = 0; i < 4; i++)
        if (w_be[i]) mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed checks of the data memory responder against a reference model
module tb_data_mem_responder;
  localparam int DEPTH = 64;
  localparam int WAITC = 2;
  logic        CLK = 1'b0, Reset = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic [31:0] rdata;
  logic        ack, err, busy;
  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic [3:0]  be0 = '0;
  logic [31:0] rdata0;
  logic        ack0, err0, busy0;
  logic [31:0] model [DEPTH];
  int n_chk = 0, n_fail = 0;
  logic [31:0] got;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .CLK(CLK), .Reset(Reset), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .rdata(rdata), .ack(ack), .err(err), .busy(busy));

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .CLK(CLK), .Reset(Reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0), .be(be0),
    .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction on the WAIT_CYCLES=2 instance; starts and ends just after a falling edge
  task automatic access(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                        input logic [3:0] t_be, output logic [31:0] obs);
    logic legal;
    int lat, idx;
    logic [31:0] exp_rd;
    legal  = (t_addr[1:0] == 2'b00) && (t_addr[31:2] < DEPTH);
    idx    = int'(t_addr[7:2]);
    lat    = legal ? WAITC : 0;
    exp_rd = (legal && !t_we) ? model[idx] : 32'h0;
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; be = t_be;
    @(posedge CLK); #1;
    req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
    for (int n = 0; n < lat; n++) begin
      @(negedge CLK);
      chk("wait_ack", {31'b0, ack}, 32'h0);
      chk("wait_busy", {31'b0, busy}, 32'h1);
      @(posedge CLK);
    end
    @(negedge CLK);
    chk("ack", {31'b0, ack}, 32'h1);
    chk("err", {31'b0, err}, {31'b0, !legal});
    chk("rdata", rdata, exp_rd);
    chk("resp_busy", {31'b0, busy}, 32'h1);
    obs = rdata;
    if (legal && t_we)
      for (int b = 0; b < 4; b++) if (t_be[b]) model[idx][8*b +: 8] = t_wdata[8*b +: 8];
    @(negedge CLK);
    chk("idle_ack", {31'b0, ack}, 32'h0);
    chk("idle_busy", {31'b0, busy}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    repeat (2) @(negedge CLK);
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    Reset = 1'b0;
    @(negedge CLK);
    // Store, then reset during its RESP cycle: ack drops at once, the store stays committed
    req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'h12345678; be = 4'hF;
    @(posedge CLK); #1 req = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rresp_ack", {31'b0, ack}, 32'h1);
    model[12] = 32'h12345678;
    Reset = 1'b1;
    #1;
    chk("rresp_ack_drop", {31'b0, ack}, 32'h0);
    chk("rresp_busy", {31'b0, busy}, 32'h0);
    @(negedge CLK) Reset = 1'b0;
    @(negedge CLK);
    access(1'b0, 32'h0, 32'h0, 4'h0, got);
    chk("t1_rdata", got, 32'h0);
    access(1'b0, 32'h30, 32'h0, 4'h0, got);
    chk("rresp_kept", got, 32'h12345678);
    access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, got);
    access(1'b0, 32'h10, 32'h0, 4'h0, got);
    chk("t2_rdata", got, 32'hDEADBEEF);
    access(1'b1, 32'h10, 32'h11223344, 4'b0101, got);
    access(1'b0, 32'h10, 32'h0, 4'h0, got);
    chk("t3_rdata", got, 32'hDE22BE44);
    access(1'b0, 32'h13, 32'h0, 4'h0, got);
    access(1'b0, 32'h100, 32'h0, 4'h0, got);
    access(1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, got);
    access(1'b0, 32'h10, 32'h0, 4'h0, got);
    chk("t4_unchanged", got, 32'hDE22BE44);
    // Store aborted by reset during WAIT: no ack and no commit
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D; be = 4'hF;
    @(posedge CLK); #1 req = 1'b0;
    @(negedge CLK);
    chk("abort_busy", {31'b0, busy}, 32'h1);
    Reset = 1'b1;
    #1 chk("abort_busy_drop", {31'b0, busy}, 32'h0);
    for (int n = 0; n < 3; n++) begin
      @(negedge CLK);
      chk("abort_ack", {31'b0, ack}, 32'h0);
    end
    Reset = 1'b0;
    @(negedge CLK);
    access(1'b0, 32'h20, 32'h0, 4'h0, got);
    chk("t5_rdata", got, 32'h0);
    // Randomized mix of legal, misaligned and out-of-range accesses
    for (int t = 0; t < 60; t++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r < 7) a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else if (r == 7) a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      else a = 32'($urandom_range(DEPTH, 100000)) << 2;
      access(1'($urandom), a, $urandom, 4'($urandom), got);
    end
    // Zero-wait instance: store, then two back-to-back loads with req held high
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'h5EED1234; be0 = 4'hF;
    @(posedge CLK); #1 req0 = 1'b0;
    @(negedge CLK);
    chk("z_st_ack", {31'b0, ack0}, 32'h1);
    chk("z_st_rdata", rdata0, 32'h0);
    @(negedge CLK);
    chk("z_st_idle", {31'b0, ack0}, 32'h0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    @(negedge CLK);
    chk("z_ack1", {31'b0, ack0}, 32'h1);
    chk("z_rdata1", rdata0, 32'h5EED1234);
    addr0 = 32'h14;
    #1 chk("z_rdata1_hold", rdata0, 32'h5EED1234);
    @(negedge CLK);
    chk("z_gap_ack", {31'b0, ack0}, 32'h0);
    chk("z_gap_busy", {31'b0, busy0}, 32'h0);
    addr0 = 32'h10;
    @(negedge CLK);
    chk("z_ack2", {31'b0, ack0}, 32'h1);
    chk("z_err2", {31'b0, err0}, 32'h0);
    chk("z_rdata2", rdata0, 32'h5EED1234);
    req0 = 1'b0;
    @(negedge CLK);
    chk("z_end_ack", {31'b0, ack0}, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
